// File: rtl/winograd_pkg.sv
// Shared constants and state type for the Winograd output-tile assembler.
package winograd_pkg;

    localparam int TILE_N  = 4;
    localparam int IMG_H   = 8;
    localparam int IMG_W   = 10;
    localparam int GRID_R  = 2;
    localparam int GRID_C  = 3;
    localparam int N_TILES = GRID_R * GRID_C;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } asm_state_t;

endpackage

// File: rtl/tile_asm_8x10_ctrl.sv
// Assembles six 4x4 tiles into an 8x10 image and streams it out row by row.
// Optional tile_last consistency checker (err port) enabled by TILE_ASM_LAST_CHECK_EN.
module tile_asm_8x10_ctrl
    import winograd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             tile_valid,
    output logic                             tile_ready,
    input  logic [0:3][0:3][DATA_W-1:0]      tile_data,
    input  logic                             tile_last,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [0:9][DATA_W-1:0]           row_data,
    output logic [2:0]                       row_idx,
    output logic                             row_last,
    output logic                             busy
`ifdef TILE_ASM_LAST_CHECK_EN
    ,
    output logic                             err
`endif
);

    // state | meaning
    // COLLECT | accepting tiles, k counts tiles held so far
    // DRAIN   | image complete, presenting rows 0..7
    asm_state_t state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [2:0] row_idx_q, row_idx_d;

    logic [DATA_W-1:0] img_q [0:IMG_H-1][0:IMG_W-1];
    logic [DATA_W-1:0] img_d [0:IMG_H-1][0:IMG_W-1];

    logic       tile_acc;
    logic       row_acc;
    logic       k_is_last;
    logic [2:0] row_base;
    logic [3:0] col_base;

    assign tile_acc  = tile_valid && (state_q == COLLECT);
    assign row_acc   = row_ready && (state_q == DRAIN);
    assign k_is_last = (k_q == 3'(N_TILES - 1));

    always_comb begin
        row_base = (k_q >= 3'(GRID_C)) ? 3'(TILE_N) : 3'd0;
        case (k_q)
            3'd1, 3'd4: col_base = 4'(TILE_N);
            3'd2, 3'd5: col_base = 4'(2 * TILE_N);
            default:    col_base = 4'd0;
        endcase
    end

    // Grid column 2 overhangs the 10-wide image; its last two tile columns are dropped.
    always_comb begin
        img_d = img_q;
        if (tile_acc && !flush) begin
            for (int i = 0; i < TILE_N; i++) begin
                for (int j = 0; j < TILE_N; j++) begin
                    if (col_base + 4'(j) <= 4'(IMG_W - 1)) begin
                        img_d[row_base + 3'(i)][col_base + 4'(j)] = tile_data[i][j];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_idx_d = row_idx_q;
        if (flush) begin
            state_d   = COLLECT;
            k_d       = 3'd0;
            row_idx_d = 3'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (tile_acc) begin
                        if (k_is_last) begin
                            state_d = DRAIN;
                            k_d     = 3'd0;
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (row_acc) begin
                        if (row_idx_q == 3'(IMG_H - 1)) begin
                            state_d   = COLLECT;
                            row_idx_d = 3'd0;
                        end else begin
                            row_idx_d = row_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d   = COLLECT;
                    k_d       = 3'd0;
                    row_idx_d = 3'd0;
                end
            endcase
        end
    end

`ifdef TILE_ASM_LAST_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (flush) begin
            err_d = 1'b0;
        end else if (tile_acc && (tile_last != k_is_last)) begin
            err_d = 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tile_last;
    assign unused_tile_last = tile_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            k_q       <= 3'd0;
            row_idx_q <= 3'd0;
`ifdef TILE_ASM_LAST_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_idx_q <= row_idx_d;
`ifdef TILE_ASM_LAST_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    // Image storage is deliberately left out of reset; every cell is rewritten per image.
    always_ff @(posedge clk) begin
        img_q <= img_d;
    end

    always_comb begin
        for (int c = 0; c < IMG_W; c++) begin
            row_data[c] = img_q[row_idx_q][c];
        end
    end

    assign tile_ready = (state_q == COLLECT);
    assign row_valid  = (state_q == DRAIN);
    assign row_idx    = row_idx_q;
    assign row_last   = (state_q == DRAIN) && (row_idx_q == 3'(IMG_H - 1));
    assign busy       = (state_q == DRAIN) || (k_q != 3'd0);

endmodule

// File: tb/tb_tile_asm_8x10_ctrl.sv
// Directed bench for tile_asm_8x10_ctrl; err checks active with TILE_ASM_LAST_CHECK_EN.
module tb_tile_asm_8x10_ctrl;
    import winograd_pkg::*;

    localparam int DW = 32;
    typedef logic [10*DW-1:0] wide_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic                      flush;
    logic                      tile_valid;
    logic                      tile_ready;
    logic [0:3][0:3][DW-1:0]   tile_data;
    logic                      tile_last;
    logic                      row_valid;
    logic                      row_ready;
    logic [0:9][DW-1:0]        row_data;
    logic [2:0]                row_idx;
    logic                      row_last;
    logic                      busy;
`ifdef TILE_ASM_LAST_CHECK_EN
    logic                      err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int last_bad_k = -1;
    bit poison = 1'b0;

    tile_asm_8x10_ctrl #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_data  (tile_data),
        .tile_last  (tile_last),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .busy       (busy)
`ifdef TILE_ASM_LAST_CHECK_EN
        ,
        .err        (err)
`endif
    );

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image cell (r,c) comes from tile k=3*(r/4)+c/4, element [r%4][c%4].
    function automatic wide_t exp_row(input int base, input int r);
        logic [0:9][DW-1:0] e;
        for (int c = 0; c < 10; c++) begin
            e[c] = DW'(base + 16 * (3 * (r / 4) + c / 4) + 4 * (r % 4) + (c % 4));
        end
        return wide_t'(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tile(input int kk, input int base);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tile_data[i][j] = DW'(base + 16 * kk + 4 * i + j);
            end
        end
        if (poison && kk == 2) begin
            tile_data[0][2] = 32'hDEAD;
            tile_data[0][3] = 32'hBEEF;
        end
        tile_valid = 1'b1;
        tile_last  = (kk == 5) || (kk == last_bad_k);
        chk("tile_ready_collect", wide_t'(tile_ready), wide_t'(1));
        tick();
        tile_valid = 1'b0;
        tile_last  = 1'b0;
    endtask

    task automatic send_image(input int base);
        for (int kk = 0; kk < 6; kk++) begin
            send_tile(kk, base);
            if (kk == 0) chk("busy_after_tile0", wide_t'(busy), wide_t'(1));
`ifdef TILE_ASM_LAST_CHECK_EN
            if (last_bad_k >= 0) begin
                chk("err_track", wide_t'(err), wide_t'(kk >= last_bad_k));
            end
`endif
        end
        chk("drain_row_valid", wide_t'(row_valid), wide_t'(1));
        chk("drain_row_idx0", wide_t'(row_idx), wide_t'(0));
    endtask

    task automatic drain_all(input int base);
        bit found = 1'b0;
        row_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            chk("row_valid", wide_t'(row_valid), wide_t'(1));
            chk("row_idx", wide_t'(row_idx), wide_t'(r));
            chk("row_last", wide_t'(row_last), wide_t'(r == 7));
            chk("row_data", wide_t'(row_data), exp_row(base, r));
            chk("tile_ready_drain", wide_t'(tile_ready), wide_t'(0));
            for (int c = 0; c < 10; c++) begin
                if (row_data[c] == 32'hDEAD || row_data[c] == 32'hBEEF) found = 1'b1;
            end
            tick();
        end
        row_ready = 1'b0;
        chk("discarded_cols_absent", wide_t'(found), wide_t'(0));
        chk("post_drain_row_valid", wide_t'(row_valid), wide_t'(0));
        chk("post_drain_busy", wide_t'(busy), wide_t'(0));
        chk("post_drain_tile_ready", wide_t'(tile_ready), wide_t'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int cyc;
        bit rr;
        bit fire;

        rst_n      = 1'b0;
        flush      = 1'b0;
        tile_valid = 1'b0;
        tile_last  = 1'b0;
        row_ready  = 1'b0;
        tile_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_tile_ready", wide_t'(tile_ready), wide_t'(1));
        chk("rst_row_valid", wide_t'(row_valid), wide_t'(0));
        chk("rst_row_last", wide_t'(row_last), wide_t'(0));
        chk("rst_busy", wide_t'(busy), wide_t'(0));
`ifdef TILE_ASM_LAST_CHECK_EN
        chk("rst_err", wide_t'(err), wide_t'(0));
`endif

        // Plain image, no backpressure.
        send_image(0);
        drain_all(0);
`ifdef TILE_ASM_LAST_CHECK_EN
        chk("err_clean_image", wide_t'(err), wide_t'(0));
`endif

        // Stalled drain with tile_valid held high throughout.
        send_image(32'h100);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tile_data[i][j] = 32'h5555;
        tile_valid = 1'b1;
        hs  = 0;
        cyc = 0;
        while (hs < 8 && cyc < 64) begin
            rr = (cyc % 4 == 0) || (cyc % 4 == 3);
            row_ready = rr;
            chk("stall_row_idx", wide_t'(row_idx), wide_t'(hs));
            chk("stall_row_data", wide_t'(row_data), exp_row(32'h100, hs));
            chk("stall_tile_ready", wide_t'(tile_ready), wide_t'(0));
            fire = row_valid && rr;
            tick();
            if (fire) hs++;
            cyc++;
        end
        tile_valid = 1'b0;
        row_ready  = 1'b0;
        chk("stall_handshakes", wide_t'(hs), wide_t'(8));
        chk("stall_cycles", wide_t'(cyc), wide_t'(16));
        chk("stall_no_tile_taken", wide_t'(busy), wide_t'(0));
        chk("stall_row_valid_end", wide_t'(row_valid), wide_t'(0));

        // Overhang columns of tile 2 carry sentinel values that must vanish.
        poison = 1'b1;
        send_image(32'h300);
        chk("img0_col8", wide_t'(row_data[8]), wide_t'(32'h300 + 32));
        chk("img0_col9", wide_t'(row_data[9]), wide_t'(32'h300 + 33));
        drain_all(32'h300);
        poison = 1'b0;

        // Flush after three tiles, then a fresh image.
        for (int kk = 0; kk < 3; kk++) send_tile(kk, 32'h500);
        chk("pre_flush_busy", wide_t'(busy), wide_t'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", wide_t'(busy), wide_t'(0));
        chk("flush_tile_ready", wide_t'(tile_ready), wide_t'(1));
        send_image(32'h600);
        drain_all(32'h600);

        // Flush colliding with a row handshake at row 3.
        send_image(32'h700);
        row_ready = 1'b1;
        repeat (3) tick();
        chk("pre_flush_row_idx", wide_t'(row_idx), wide_t'(3));
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        row_ready = 1'b0;
        chk("hsflush_row_valid", wide_t'(row_valid), wide_t'(0));
        chk("hsflush_tile_ready", wide_t'(tile_ready), wide_t'(1));
        chk("hsflush_busy", wide_t'(busy), wide_t'(0));
        chk("hsflush_row_idx", wide_t'(row_idx), wide_t'(0));
        send_image(32'h800);
        drain_all(32'h800);

        // Reset in the middle of a drain.
        send_image(32'h900);
        row_ready = 1'b1;
        repeat (2) tick();
        row_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_row_valid", wide_t'(row_valid), wide_t'(0));
        chk("midrst_tile_ready", wide_t'(tile_ready), wide_t'(1));
        chk("midrst_row_idx", wide_t'(row_idx), wide_t'(0));
        chk("midrst_busy", wide_t'(busy), wide_t'(0));
        send_image(32'hA00);
        drain_all(32'hA00);

`ifdef TILE_ASM_LAST_CHECK_EN
        // Misplaced tile_last on tile 3.
        last_bad_k = 3;
        send_image(32'hB00);
        drain_all(32'hB00);
        chk("err_sticky_after_drain", wide_t'(err), wide_t'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("err_cleared_by_flush", wide_t'(err), wide_t'(0));
        last_bad_k = -1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
